uart_rx_ctrl: RTL and testbench

Frame controller for the UART receive path. It sits directly after the oversampling sampler, which hands it majority-voted bits with a one-cycle valid strobe. The controller validates the start bit, assembles data bits LSB-first, and checks optional parity and the stop bit. It then drives the sampler's `stop` input to return the sampler to start-bit hunting, and presents the received byte with status flags through a valid/ready holding register.

---
 rtl/uart_rx_ctrl_pkg.sv | 25 ++
 rtl/uart_rx_ctrl_if.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive parameters: frame-controller state encodings,
// default frame format and the received-word payload.
package uart_rx_ctrl_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_PARITY_EN  = 1;
  localparam int unsigned UART_PARITY_ODD = 0;
  localparam int unsigned RX_DATA_W       = 8;
  localparam int unsigned ST_W            = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd4;
  localparam logic [ST_W-1:0] ST_FLUSH  = 3'd5;

  // Word held in the output register together with its qualifiers.
  typedef struct packed {
    logic [RX_DATA_W-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } rx_word_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Sampler-side and consumer-side signals of the UART RX frame controller.
//   master: the controller (drives smp_stop and the word/status outputs)
//   slave : sampler + consumer (drive smp_bit, smp_valid, rx_ready)
interface uart_rx_ctrl_if;
  import uart_rx_ctrl_pkg::*;

  logic                 smp_bit;
  logic                 smp_valid;
  logic                 smp_stop;
  logic [RX_DATA_W-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  smp_bit, smp_valid, rx_ready,
    output smp_stop, rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output smp_bit, smp_valid, rx_ready,
    input  smp_stop, rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller. Validates the start bit, assembles data
// bits LSB-first, checks optional parity and the stop bit, pulses smp_stop
// to re-arm the sampler and presents the word through a valid/ready slot.
// Ports: clk, rst_n (async active-low), bus (uart_rx_ctrl_if.master).
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned PARITY_EN  = UART_PARITY_EN,
  parameter int unsigned PARITY_ODD = UART_PARITY_ODD
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_ctrl_if.master bus
);

  localparam logic [2:0] LAST_CNT = 3'(DATA_BITS - 1);
  localparam logic       ODD_BIT  = 1'(PARITY_ODD);
  localparam logic       PAR_ON   = (PARITY_EN != 0);

  logic [ST_W-1:0]      state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic                 par_bad_q, par_bad_d;
  rx_word_t             word_q, word_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 smp_stop_q, smp_stop_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 commit_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. The first strobe in IDLE is the start-bit vote, so
  // the start decision is taken on that same strobe and START is never held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.smp_valid) state_d = bus.smp_bit ? ST_FLUSH : ST_DATA;
      ST_DATA:   if (bus.smp_valid && (cnt_q == LAST_CNT))
                   state_d = PAR_ON ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bus.smp_valid) state_d = ST_STOP;
      ST_STOP:   if (bus.smp_valid) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    par_bad_d  = par_bad_q;
    word_d     = word_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    commit_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.smp_valid && !bus.smp_bit) begin
          sh_d      = '0;
          cnt_d     = 3'd0;
          acc_d     = 1'b0;
          par_bad_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (bus.smp_valid) begin
          sh_d  = {bus.smp_bit, sh_q[DATA_BITS-1:1]};
          acc_d = acc_q ^ bus.smp_bit;
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (bus.smp_valid) par_bad_d = acc_q ^ bus.smp_bit ^ ODD_BIT;
      end
      ST_STOP: commit_c = bus.smp_valid;
      default: ;
    endcase

    // A handshake in the commit cycle frees the slot for the new word.
    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
    if (commit_c) begin
      if (!rx_valid_q || bus.rx_ready) begin
        word_d.data       = RX_DATA_W'(sh_q);
        word_d.parity_err = PAR_ON ? par_bad_q : 1'b0;
        word_d.frame_err  = !bus.smp_bit;
        rx_valid_d        = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    smp_stop_d = (state_d == ST_FLUSH);
    busy_d     = (state_d != ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      cnt_q      <= 3'd0;
      acc_q      <= 1'b0;
      par_bad_q  <= 1'b0;
      word_q     <= '0;
      rx_valid_q <= 1'b0;
      smp_stop_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      par_bad_q  <= par_bad_d;
      word_q     <= word_d;
      rx_valid_q <= rx_valid_d;
      smp_stop_q <= smp_stop_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.smp_stop   = smp_stop_q;
  assign bus.rx_data    = word_q.data;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = word_q.parity_err;
  assign bus.frame_err  = word_q.frame_err;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8E1 instance checked every cycle against a
// frame-level model, plus a 5N1 instance checked with literal values.
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_ctrl_if if_a ();
  uart_rx_ctrl_if if_b ();

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  uart_rx_ctrl #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // What the driver is presenting this cycle, as frame-level facts.
  logic       drv_first = 1'b0;
  logic       drv_last  = 1'b0;
  logic       drv_good  = 1'b0;
  logic [7:0] drv_data  = 8'h00;
  logic       drv_perr  = 1'b0;
  logic       drv_ferr  = 1'b0;
  logic       ready_idle = 1'b0;

  // Frame-level model of the 8E1 instance.
  logic       m_valid, m_stop, m_ovr, m_busy, m_perr, m_ferr;
  logic [7:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_stop <= 1'b0; m_ovr <= 1'b0; m_busy <= 1'b0;
      m_perr  <= 1'b0; m_ferr <= 1'b0; m_data <= 8'h00;
    end else begin
      m_stop <= drv_last;
      m_ovr  <= 1'b0;
      if (drv_last)       m_busy <= 1'b1;
      else if (m_stop)    m_busy <= 1'b0;
      else if (drv_first) m_busy <= 1'b1;
      if (drv_last && drv_good) begin
        if (!m_valid || if_a.rx_ready) begin
          m_valid <= 1'b1;
          m_data  <= drv_data;
          m_perr  <= drv_perr;
          m_ferr  <= drv_ferr;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && if_a.rx_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of the 8E1 instance against the model.
  always @(negedge clk) begin
    chk("smp_stop", 32'(if_a.smp_stop), 32'(m_stop));
    chk("busy",     32'(if_a.busy),     32'(m_busy));
    chk("rx_valid", 32'(if_a.rx_valid), 32'(m_valid));
    chk("overrun",  32'(if_a.overrun),  32'(m_ovr));
    if (m_valid) begin
      chk("rx_data",    32'(if_a.rx_data),    32'(m_data));
      chk("parity_err", 32'(if_a.parity_err), 32'(m_perr));
      chk("frame_err",  32'(if_a.frame_err),  32'(m_ferr));
    end
  end

  task automatic strobe(input logic b, input logic first, input logic last,
                        input logic good, input logic rdy);
    @(negedge clk);
    if_a.smp_valid = 1'b1; if_a.smp_bit = b; if_a.rx_ready = rdy;
    drv_first = first; drv_last = last; drv_good = good;
    @(negedge clk);
    if_a.smp_valid = 1'b0; if_a.rx_ready = ready_idle;
    drv_first = 1'b0; drv_last = 1'b0; drv_good = 1'b0;
  endtask

  // 8E1 frame; returns in the cycle after the stop strobe.
  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop_b, input logic rdy_stop);
    logic p;
    p = (^d) ^ par_flip;
    drv_data = d;
    drv_perr = ^{d, p};
    drv_ferr = !stop_b;
    strobe(1'b0, 1'b1, 1'b0, 1'b0, ready_idle);
    for (int i = 0; i < 8; i++) strobe(d[i], 1'b0, 1'b0, 1'b0, ready_idle);
    strobe(p, 1'b0, 1'b0, 1'b0, ready_idle);
    strobe(stop_b, 1'b0, 1'b1, 1'b1, rdy_stop | ready_idle);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drain;
    @(negedge clk); if_a.rx_ready = 1'b1;
    @(negedge clk); if_a.rx_ready = ready_idle;
  endtask

  task automatic strobe_b(input logic b);
    @(negedge clk); if_b.smp_valid = 1'b1; if_b.smp_bit = b;
    @(negedge clk); if_b.smp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_a.smp_bit = 1'b0; if_a.smp_valid = 1'b0; if_a.rx_ready = 1'b0;
    if_b.smp_bit = 1'b0; if_b.smp_valid = 1'b0; if_b.rx_ready = 1'b0;
    idle(2);
    chk("rst_rx_data",  32'(if_a.rx_data),  32'h0);
    chk("rst_rx_valid", 32'(if_a.rx_valid), 32'h0);
    chk("rst_busy",     32'(if_a.busy),     32'h0);
    rst_n = 1'b1;
    idle(2);

    // 8E1 0xA5, clean frame.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("a5_data",     32'(if_a.rx_data),    32'hA5);
    chk("a5_model",    32'(m_data),          32'hA5);
    chk("a5_valid",    32'(if_a.rx_valid),   32'h1);
    chk("a5_perr",     32'(if_a.parity_err), 32'h0);
    chk("a5_ferr",     32'(if_a.frame_err),  32'h0);
    chk("a5_smp_stop", 32'(if_a.smp_stop),   32'h1);
    idle(1);
    chk("a5_stop_once", 32'(if_a.smp_stop), 32'h0);
    chk("a5_idle_busy", 32'(if_a.busy),     32'h0);
    drain();
    idle(2);

    // Parity bit flipped to 1.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("par_data", 32'(if_a.rx_data),    32'hA5);
    chk("par_err",  32'(if_a.parity_err), 32'h1);
    drain();
    idle(2);

    // Stop bit sampled 0.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("frm_err",  32'(if_a.frame_err),  32'h1);
    chk("frm_perr", 32'(if_a.parity_err), 32'h0);
    drain();
    idle(2);

    // False start, then 0x3C.
    strobe(1'b1, 1'b1, 1'b1, 1'b0, ready_idle);
    chk("fs_smp_stop", 32'(if_a.smp_stop), 32'h1);
    chk("fs_valid",    32'(if_a.rx_valid), 32'h0);
    idle(2);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("3c_data", 32'(if_a.rx_data), 32'h3C);
    drain();
    idle(2);

    // Overrun, then commit in the same cycle as a handshake.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    idle(2);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    chk("ovr_pulse", 32'(if_a.overrun), 32'h1);
    chk("ovr_keep",  32'(if_a.rx_data), 32'h11);
    idle(2);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1);
    chk("hs_data",  32'(if_a.rx_data),  32'h33);
    chk("hs_valid", 32'(if_a.rx_valid), 32'h1);
    chk("hs_ovr",   32'(if_a.overrun),  32'h0);
    drain();
    idle(2);

    // Pending word plus partial frame lost by a mid-frame reset.
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    idle(2);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, ready_idle);
    for (int i = 0; i < 4; i++) strobe(i[0], 1'b0, 1'b0, 1'b0, ready_idle);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy",  32'(if_a.busy),     32'h0);
    chk("mr_valid", 32'(if_a.rx_valid), 32'h0);
    chk("mr_data",  32'(if_a.rx_data),  32'h0);
    rst_n = 1'b1;
    idle(2);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0);
    chk("7e_data", 32'(if_a.rx_data), 32'h7E);
    chk("7e_perr", 32'(if_a.parity_err), 32'h0);
    drain();
    idle(2);

    // 5N1 instance: data 0x1B = bits 1,1,0,1,1 LSB-first.
    strobe_b(1'b0);
    chk("b_busy", 32'(if_b.busy), 32'h1);
    strobe_b(1'b1); strobe_b(1'b1); strobe_b(1'b0); strobe_b(1'b1); strobe_b(1'b1);
    strobe_b(1'b1);
    chk("b_data",     32'(if_b.rx_data),      32'h1B);
    chk("b_hi_zero",  32'(if_b.rx_data[7:5]), 32'h0);
    chk("b_valid",    32'(if_b.rx_valid),     32'h1);
    chk("b_perr",     32'(if_b.parity_err),   32'h0);
    chk("b_ferr",     32'(if_b.frame_err),    32'h0);
    chk("b_smp_stop", 32'(if_b.smp_stop),     32'h1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
